// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Packet-aware round-robin arbiter that shares one async-FIFO write port
//   among NREQ requesters in the wclk domain. A requester that wins keeps the
//   port until it transfers a word flagged last. Grants are zero-latency: the
//   word offered by the winner is written in the same cycle it is granted.
//   Nothing is written while wfull is high.
//
// Ports:
//   wclk        in   write-domain clock
//   wrst        in   asynchronous active-low reset
//   req         in   per-requester valid
//   req_data    in   requester i word at [i*DW +: DW]
//   req_last    in   final word of the requester's packet
//   gnt         out  one-hot ready (transfer when req[i] & gnt[i])
//   wfull       in   FIFO full flag (registered, wclk domain)
//   winc        out  FIFO write enable
//   wdata       out  FIFO write data
//   locked      out  a packet is in progress
//   owner       out  index of current or last owner
//   stat_words  out  accepted-word counter (saturating)
//   stat_stall  out  cycles an eligible request was blocked by wfull
//
// Optional feature:
//   FIFO_WR_ARB_STATS_EN - when defined, stat_words/stat_stall are live
//   16-bit saturating counters; otherwise both ports are tied to zero.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    gnt,
  input  logic              wfull,
  output logic              winc,
  output logic [DW-1:0]      wdata,
  output logic              locked,
  output logic [IDW-1:0]     owner,
  output logic [15:0]        stat_words,
  output logic [15:0]        stat_stall
);

  typedef enum logic {ARB, LOCK} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic           locked_q, locked_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] sel_idx;
  logic           sel_req;
  logic           sel_last;
  int             idx;

  // Successor of a requester index, wrapping at NREQ-1 so the pointer never
  // holds a value outside 0..NREQ-1 even when NREQ is not a power of two.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (i == IDW'(NREQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin scan starting at rr_ptr; modulo done in integer space so the
  // wrap is correct for any NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Port selected for this cycle: the locked owner, or the scan winner.
  always_comb begin
    sel_idx  = (state_q == LOCK) ? owner_q : win_idx;
    sel_req  = 1'b0;
    sel_last = 1'b0;
    wdata    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IDW'(i)) begin
        sel_req  = req[i];
        sel_last = req_last[i];
        wdata    = req_data[i*DW +: DW];
      end
    end
  end

  // Grant/write decode; wfull masks everything so no word is ever dropped.
  always_comb begin
    gnt  = '0;
    winc = 1'b0;
    if (!wfull) begin
      if (state_q == LOCK) begin
        gnt  = NREQ'(1) << owner_q;
        winc = sel_req;
      end else if (win_found) begin
        gnt  = NREQ'(1) << win_idx;
        winc = 1'b1;
      end
    end
  end

  // Next-state: rr_ptr only moves when a packet completes.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    if (state_q == ARB) begin
      if (winc) begin
        owner_d = win_idx;
        if (sel_last) begin
          rr_ptr_d = next_idx(win_idx);
        end else begin
          state_d  = LOCK;
          locked_d = 1'b1;
        end
      end
    end else begin
      if (winc && sel_last) begin
        state_d  = ARB;
        locked_d = 1'b0;
        rr_ptr_d = next_idx(owner_q);
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
  assign owner  = owner_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] words_q, words_d;
  logic [15:0] stall_q, stall_d;
  logic        stall_cond;

  // Only a request that could actually be served counts as stalled: any
  // request while arbitrating, but only the owner's while locked.
  always_comb begin
    stall_cond = wfull & ((state_q == LOCK) ? sel_req : (|req));
    words_d    = words_q;
    stall_d    = stall_q;
    if (winc && (words_q != 16'hFFFF))       words_d = words_q + 16'd1;
    if (stall_cond && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`else
  assign stat_words = 16'd0;
  assign stat_stall = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Scoreboard bench for fifo_wr_arbiter. The driver applies one cycle of
// stimulus, computes the expected response from a queue/arithmetic model of
// the arbitration rules and pushes it; a monitor on the falling edge pops and
// compares. Directed scenarios come first, then a randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    gnt;
  logic              wfull;
  logic              winc;
  logic [DW-1:0]      wdata;
  logic              locked;
  logic [IDW-1:0]     owner;
  logic [15:0]        stat_words;
  logic [15:0]        stat_stall;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
    .req_last(req_last), .gnt(gnt), .wfull(wfull), .winc(winc),
    .wdata(wdata), .locked(locked), .owner(owner),
    .stat_words(stat_words), .stat_stall(stat_stall)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic            locked;
    int              owner;
    int              sw;
    int              ss;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  // Reference model state
  int m_rr, m_own, m_sw, m_ss;
  bit m_lk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_own = 0; m_lk = 0; m_sw = 0; m_ss = 0;
  endtask

  // Apply one cycle of stimulus and push the expected response.
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic f, input logic [NREQ*DW-1:0] d);
    exp_t e;
    int   w;
    @(posedge wclk); #1;
    req = r; req_last = l; wfull = f; req_data = d;
    e.gnt = '0; e.winc = 1'b0; e.wdata = '0;
    e.locked = m_lk; e.owner = m_own; e.sw = m_sw; e.ss = m_ss;
    w = -1;
    if (!f) begin
      if (m_lk) w = m_own;
      else
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && r[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
    end
    if (w >= 0) begin
      e.gnt = NREQ'(1) << w;
      if (r[w]) begin
        e.winc  = 1'b1;
        e.wdata = d[w*DW +: DW];
      end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    if (e.winc && m_sw < 65535) m_sw++;
    if (f && (m_lk ? r[m_own] : (|r)) && m_ss < 65535) m_ss++;
`endif
    if (e.winc) begin
      if (l[w]) begin
        m_lk = 0;
        m_rr = (w + 1) % NREQ;
      end else begin
        m_lk = 1;
      end
      m_own = w;
    end
    expq.push_back(e);
  endtask

  always @(negedge wclk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("gnt", 32'(gnt), 32'(mon_e.gnt));
      check("winc", 32'(winc), 32'(mon_e.winc));
      if (mon_e.winc) check("wdata", 32'(wdata), 32'(mon_e.wdata));
      check("locked", 32'(locked), 32'(mon_e.locked));
      check("owner", 32'(owner), mon_e.owner);
      check("stat_words", 32'(stat_words), mon_e.sw);
      check("stat_stall", 32'(stat_stall), mon_e.ss);
    end
  end

  logic [NREQ*DW-1:0] d;

  initial begin
    wrst = 1'b0; req = '0; req_last = '0; wfull = 1'b0; req_data = '0;
    model_reset();
    repeat (2) @(posedge wclk);
    #2;
    check("rst_locked", 32'(locked), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_winc", 32'(winc), 0);
    check("rst_stat_words", 32'(stat_words), 0);
    check("rst_stat_stall", 32'(stat_stall), 0);
    @(negedge wclk); wrst = 1'b1;

    // All requesting single-word packets: strict rotation.
    for (int c = 0; c < 8; c++) begin
      d = $urandom();
      drive(4'b1111, 4'b1111, 1'b0, d);
    end

    // Move pointer to 2, then a 3-word packet on requester 2.
    drive(4'b0011, 4'b0011, 1'b0, $urandom());
    drive(4'b0010, 4'b0010, 1'b0, $urandom());
    d = $urandom(); d[2*DW +: DW] = 8'hA1; drive(4'b0111, 4'b0011, 1'b0, d);
    d = $urandom(); d[2*DW +: DW] = 8'hA2; drive(4'b0111, 4'b0011, 1'b0, d);
    d = $urandom(); d[2*DW +: DW] = 8'hA3; drive(4'b0111, 4'b0111, 1'b0, d);
    drive(4'b1011, 4'b1111, 1'b0, $urandom());

    // Full for five cycles, then release.
    for (int c = 0; c < 5; c++) drive(4'b0011, 4'b0011, 1'b1, $urandom());
    drive(4'b0011, 4'b0011, 1'b0, $urandom());

    // Lock on owner 1, owner bubbles for two cycles while requester 3 waits.
    drive(4'b0010, 4'b0000, 1'b0, $urandom());
    drive(4'b1000, 4'b1000, 1'b0, $urandom());
    drive(4'b1000, 4'b1000, 1'b0, $urandom());
    drive(4'b1010, 4'b1010, 1'b0, $urandom());
    drive(4'b1000, 4'b1000, 1'b0, $urandom());

    // Asynchronous reset in the middle of a packet.
    drive(4'b0100, 4'b0000, 1'b0, $urandom());
    drive(4'b0100, 4'b0000, 1'b0, $urandom());
    @(negedge wclk); #1;
    wrst = 1'b0; req = 4'b0110; req_last = 4'b0000; wfull = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 0);
    check("arst_owner", 32'(owner), 0);
    check("arst_gnt", 32'(gnt), 32'(4'b0010));
    check("arst_winc", 32'(winc), 1);
    check("arst_stat_words", 32'(stat_words), 0);
    check("arst_stat_stall", 32'(stat_stall), 0);
    req = '0;
    #1 wrst = 1'b1;
    model_reset();

    // Randomized phase.
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom() & $urandom()),
            ($urandom_range(0, 4) == 0), $urandom());
    end

    repeat (3) @(posedge wclk);
    #1;
    check("scoreboard_drained", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
